// File: rtl/nes_pulse_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// nes_pkg
// Shared types and default timing for the NES controller pulse sequencer.
//   nes_seq_state_t : sequencer FSM state encoding
//   NES_*           : default latch/clock timing and button count
// ---------------------------------------------------------------------------
package nes_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        HIGH  = 2'd2,
        LOW   = 2'd3
    } nes_seq_state_t;

    localparam int NES_LATCH_CYC   = 24;
    localparam int NES_HIGH_CYC    = 12;
    localparam int NES_LOW_CYC     = 12;
    localparam int NES_NUM_BUTTONS = 8;

endpackage : nes_pkg

// File: rtl/nes_pulse_sequencer_if.sv
// ---------------------------------------------------------------------------
// nes_pulse_sequencer_if
// Bundles the request/status and controller-pin signals of the sequencer.
//   start      : burst request (driven by master)
//   busy       : sequence in progress
//   latch      : controller latch pin
//   pulse      : controller clock pin
//   pulse_idx  : current pulse index, 0-based
//   done       : one-cycle end-of-burst strobe
// Optional build macro NES_CAPTURE_EN adds:
//   nes_data   : controller serial data, active low (driven by master)
//   data_out   : captured buttons, bit k = pulse k
//   data_valid : strobe coincident with done
// Modports: slave = the sequencer, master = the system side driving it.
// ---------------------------------------------------------------------------
interface nes_pulse_sequencer_if #(
    parameter int NUM_PULSES = nes_pkg::NES_NUM_BUTTONS
);
    localparam int IDX_W = $clog2(NUM_PULSES + 1);

    logic             start;
    logic             busy;
    logic             latch;
    logic             pulse;
    logic [IDX_W-1:0] pulse_idx;
    logic             done;
`ifdef NES_CAPTURE_EN
    logic                  nes_data;
    logic [NUM_PULSES-1:0] data_out;
    logic                  data_valid;

    modport slave (
        input  start, nes_data,
        output busy, latch, pulse, pulse_idx, done, data_out, data_valid
    );

    modport master (
        output start, nes_data,
        input  busy, latch, pulse, pulse_idx, done, data_out, data_valid
    );
`else
    modport slave (
        input  start,
        output busy, latch, pulse, pulse_idx, done
    );

    modport master (
        output start,
        input  busy, latch, pulse, pulse_idx, done
    );
`endif

endinterface : nes_pulse_sequencer_if

// File: rtl/nes_pulse_sequencer_phase_timer.sv
// ---------------------------------------------------------------------------
// nes_phase_timer
// Loadable down-counter timing one sequencer phase.
//   clk     : system clock
//   reset   : synchronous reset, active low (counter clears to 0)
//   i_load  : load i_value this cycle (has priority over i_dec)
//   i_value : value loaded, phase length minus one
//   i_dec   : decrement this cycle
//   o_zero  : counter is 0, i.e. this is the last cycle of the phase
// ---------------------------------------------------------------------------
module nes_phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_value,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_value;
        end else if (i_dec) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule : nes_phase_timer

// File: rtl/nes_pulse_sequencer.sv
// ---------------------------------------------------------------------------
// nes_pulse_sequencer
// Generates the NES controller read sequence: one latch pulse, NUM_PULSES
// clock pulses with programmable high/low widths, then a done strobe.
// MODE=0 instead produces a free-running periodic pulse (no latch, no done).
//   clk   : system clock
//   reset : synchronous reset, active low; aborts any burst without done
//   bus   : nes_pulse_sequencer_if.slave (start in; busy, latch, pulse,
//           pulse_idx, done out; all outputs registered)
// Optional build macro NES_CAPTURE_EN adds serial capture of the controller
// buttons (nes_data in; data_out, data_valid out).
// ---------------------------------------------------------------------------
module nes_pulse_sequencer
    import nes_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int LATCH_CYC  = NES_LATCH_CYC,
    parameter int HIGH_CYC   = NES_HIGH_CYC,
    parameter int LOW_CYC    = NES_LOW_CYC,
    parameter int NUM_PULSES = NES_NUM_BUTTONS,
    parameter int MODE       = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    nes_pulse_sequencer_if.slave  bus
);

    localparam int IDX_W = $clog2(NUM_PULSES + 1);

    // Counter reload values: a phase of N cycles counts N-1 down to 0.
    localparam logic [CNT_W-1:0] LATCH_LD = CNT_W'(LATCH_CYC - 1);
    localparam logic [CNT_W-1:0] HIGH_LD  = CNT_W'(HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] LOW_LD   = CNT_W'(LOW_CYC - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PULSES - 1);

    nes_seq_state_t   r_state;
    nes_seq_state_t   w_next;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_next;
    logic             r_busy;
    logic             r_latch;
    logic             r_pulse;
    logic             r_done;

    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_dec;
    logic             w_zero;
    logic             w_done;
    logic             w_last;

    nes_phase_timer #(
        .CNT_W (CNT_W)
    ) u_phase_timer (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_value (w_load_val),
        .i_dec   (w_dec),
        .o_zero  (w_zero)
    );

    assign w_last = (r_idx == LAST_IDX);

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and infers a latch.
    always_comb begin
        w_next     = r_state;
        w_idx_next = r_idx;
        w_load     = 1'b0;
        w_load_val = '0;
        w_dec      = 1'b0;
        w_done     = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (MODE == 0) begin
                    // Free-running: leave IDLE on the first cycle out of reset.
                    w_next     = HIGH;
                    w_load     = 1'b1;
                    w_load_val = HIGH_LD;
                end else if (bus.start) begin
                    w_next     = LATCH;
                    w_load     = 1'b1;
                    w_load_val = LATCH_LD;
                end
            end

            LATCH: begin
                if (w_zero) begin
                    w_next     = HIGH;
                    w_load     = 1'b1;
                    w_load_val = HIGH_LD;
                end else begin
                    w_dec = 1'b1;
                end
            end

            HIGH: begin
                if (w_zero) begin
                    w_next     = LOW;
                    w_load     = 1'b1;
                    w_load_val = LOW_LD;
                end else begin
                    w_dec = 1'b1;
                end
            end

            LOW: begin
                if (w_zero) begin
                    if (w_last) begin
                        w_idx_next = '0;
                        if (MODE == 0) begin
                            w_next     = HIGH;
                            w_load     = 1'b1;
                            w_load_val = HIGH_LD;
                        end else begin
                            w_next = IDLE;
                            w_done = 1'b1;
                        end
                    end else begin
                        w_idx_next = r_idx + 1'b1;
                        w_next     = HIGH;
                        w_load     = 1'b1;
                        w_load_val = HIGH_LD;
                    end
                end else begin
                    w_dec = 1'b1;
                end
            end

            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Pin outputs are registered from the next state so they line up
    // exactly with the state they describe.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_latch <= 1'b0;
            r_pulse <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_idx   <= w_idx_next;
            r_busy  <= (w_next != IDLE);
            r_latch <= (w_next == LATCH);
            r_pulse <= (w_next == HIGH);
            r_done  <= w_done;
        end
    end

    assign bus.busy      = r_busy;
    assign bus.latch     = r_latch;
    assign bus.pulse     = r_pulse;
    assign bus.pulse_idx = r_idx;
    assign bus.done      = r_done;

`ifdef NES_CAPTURE_EN
    logic [NUM_PULSES-1:0] r_shift;
    logic [NUM_PULSES-1:0] r_data_out;
    logic                  r_data_valid;

    // Bit 0 comes from the last LATCH cycle, bit k from the last HIGH cycle
    // of pulse k-1; the final pulse's HIGH sample has no slot and is dropped.
    // NOTE: the capture store is cleared by reset like any other register;
    // it is a few flops, not a RAM, so the reset costs nothing structural.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_shift      <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
        end else begin
            if (MODE != 0) begin
                if (r_state == LATCH && w_zero) begin
                    r_shift[0] <= ~bus.nes_data;
                end
                for (int k = 1; k < NUM_PULSES; k++) begin
                    if (r_state == HIGH && w_zero && r_idx == IDX_W'(k - 1)) begin
                        r_shift[k] <= ~bus.nes_data;
                    end
                end
            end
            r_data_valid <= w_done;
            if (w_done) begin
                r_data_out <= r_shift;
            end
        end
    end

    assign bus.data_out   = r_data_out;
    assign bus.data_valid = r_data_valid;
`endif

endmodule : nes_pulse_sequencer

// File: tb/tb_nes_pulse_sequencer.sv
// ---------------------------------------------------------------------------
// tb_nes_pulse_sequencer
// Directed bench for nes_pulse_sequencer. dut_a uses default timing in burst
// mode; dut_b runs free-running with HIGH_CYC=3, LOW_CYC=2. Capture checks
// are compiled in when NES_CAPTURE_EN is defined.
// ---------------------------------------------------------------------------
module tb_nes_pulse_sequencer;

    logic clk;
    logic reset;
    logic reset_b;

    int n_cmp  = 0;
    int n_fail = 0;

    nes_pulse_sequencer_if #(.NUM_PULSES(8)) bus_a ();
    nes_pulse_sequencer_if #(.NUM_PULSES(8)) bus_b ();

    nes_pulse_sequencer #(
        .CNT_W      (8),
        .LATCH_CYC  (24),
        .HIGH_CYC   (12),
        .LOW_CYC    (12),
        .NUM_PULSES (8),
        .MODE       (1)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    nes_pulse_sequencer #(
        .CNT_W      (8),
        .LATCH_CYC  (24),
        .HIGH_CYC   (3),
        .LOW_CYC    (2),
        .NUM_PULSES (8),
        .MODE       (0)
    ) dut_b (
        .clk   (clk),
        .reset (reset_b),
        .bus   (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // {busy, latch, pulse, done, pulse_idx}
    function automatic logic [7:0] vec_a();
        return {bus_a.busy, bus_a.latch, bus_a.pulse, bus_a.done, bus_a.pulse_idx};
    endfunction

    function automatic logic [7:0] vec_b();
        return {bus_b.busy, bus_b.latch, bus_b.pulse, bus_b.done, bus_b.pulse_idx};
    endfunction

    function automatic logic [7:0] mk(input logic b, input logic l, input logic p,
                                      input logic d, input int idx);
        logic [3:0] i4;
        i4 = 4'(idx);
        return {b, l, p, d, i4};
    endfunction

    // Called in cycle T+1 of a burst; walks cycles T+1..T+217 (ends in the
    // done cycle). Optionally pokes start mid-burst and/or in the done cycle,
    // and drives nes_data so the captured word should equal pat.
    task automatic run_burst(input string tag, input bit poke_mid, input bit chain,
                             input logic [7:0] pat);
        logic [7:0] exp;
        int         p;
        logic       b;
        for (int k = 1; k <= 217; k++) begin
            if (k <= 24) begin
                exp = mk(1'b1, 1'b1, 1'b0, 1'b0, 0);
            end else if (k <= 216) begin
                exp = mk(1'b1, 1'b0, ((k - 25) % 24) < 12, 1'b0, (k - 25) / 24);
            end else begin
                exp = mk(1'b0, 1'b0, 1'b0, 1'b1, 0);
            end
            check($sformatf("%s k=%0d", tag, k), 32'(vec_a()), 32'(exp));
`ifdef NES_CAPTURE_EN
            if (k == 216) check($sformatf("%s valid_pre", tag), 32'(bus_a.data_valid), 32'd0);
            if (k == 217) begin
                check($sformatf("%s valid", tag), 32'(bus_a.data_valid), 32'd1);
                check($sformatf("%s data", tag), 32'(bus_a.data_out), 32'(pat));
            end
            if (k <= 24) begin
                b = pat[0];
            end else begin
                p = (k - 25) / 24;
                b = (p < 7) ? pat[p + 1] : 1'b0;
            end
            bus_a.nes_data = ~b;
`else
            b = pat[0];
`endif
            bus_a.start = (poke_mid && k == 50) || (chain && k == 217);
            if (k < 217) step();
        end
    endtask

    initial begin
        reset       = 1'b0;
        reset_b     = 1'b0;
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
`ifdef NES_CAPTURE_EN
        bus_a.nes_data = 1'b1;
        bus_b.nes_data = 1'b1;
`endif

        // 1. Reset state, then idle with no start.
        repeat (3) step();
        check("reset_a", 32'(vec_a()), 32'd0);
        check("reset_b", 32'(vec_b()), 32'd0);
`ifdef NES_CAPTURE_EN
        check("reset_data", 32'(bus_a.data_out), 32'd0);
        check("reset_valid", 32'(bus_a.data_valid), 32'd0);
`endif
        reset = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            check($sformatf("idle c=%0d", i), 32'(vec_a()), 32'd0);
        end

        // 2+3. Full burst with a mid-burst start that must be ignored and a
        // start in the done cycle that chains a second burst.
        bus_a.start = 1'b1;
        step();
        run_burst("burst_a", 1'b1, 1'b1, 8'h00);
        step();
        bus_a.start = 1'b0;
        run_burst("burst_b", 1'b0, 1'b0, 8'hA5);
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("post_b c=%0d", i), 32'(vec_a()), 32'd0);
`ifdef NES_CAPTURE_EN
            check($sformatf("hold_b c=%0d", i), 32'(bus_a.data_out), 32'hA5);
`endif
        end

        // 4. Reset mid-burst aborts without done; a fresh burst follows.
        bus_a.start = 1'b1;
        step();
        bus_a.start = 1'b0;
        repeat (99) step();
        reset = 1'b0;
        step();
        check("abort", 32'(vec_a()), 32'd0);
`ifdef NES_CAPTURE_EN
        check("abort_data", 32'(bus_a.data_out), 32'd0);
`endif
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("post_abort c=%0d", i), 32'(vec_a()), 32'd0);
        end
        bus_a.start = 1'b1;
        step();
        bus_a.start = 1'b0;
        run_burst("burst_c", 1'b0, 1'b0, 8'h3C);

        // 5. Free-running mode: 3 high, 2 low, index wraps 7 -> 0.
        check("free_pre", 32'(vec_b()), 32'd0);
        reset_b = 1'b1;
        step();
        for (int n = 0; n < 45; n++) begin
            check($sformatf("free n=%0d", n), 32'(vec_b()),
                  32'(mk(1'b1, 1'b0, (n % 5) < 3, 1'b0, (n / 5) % 8)));
`ifdef NES_CAPTURE_EN
            check($sformatf("free_valid n=%0d", n), 32'(bus_b.data_valid), 32'd0);
`endif
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_nes_pulse_sequencer
